bcd_digit_packer: RTL and testbench
===================================

BCD_DIGIT_PACKER -- requirements
Module: bcd_digit_packer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD digits per packed word (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port bcd_in, input, 4 bits, one BCD digit from the upstream Excess-3-to-BCD stage.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning bcd_in is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the packer accepts a digit this cycle.
REQ-007 SHALL have port flush, input, 1 bit, requesting emission of a partial word.
REQ-008 SHALL have port packed_out, output, 4*NUM_DIGITS bits, the packed BCD word.
REQ-009 SHALL have port out_count, output, 4 bits, the number of valid digits in packed_out.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning packed_out and out_count are valid.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning downstream consumes the word.
REQ-012 SHALL have port digit_err, output, 1 bit, a sticky invalid-digit flag; this port exists only when the Configuration macro is defined.

Function
REQ-013 SHALL implement two states, FILL and HOLD; in_ready = 1 in FILL and 0 in HOLD; out_valid = 1 in HOLD and 0 in FILL.
REQ-014 SHALL accept a digit when in_valid and in_ready are both 1; the accumulator shifts left by 4 and bcd_in enters the low nibble, so the first digit accepted is the most significant.
REQ-015 SHALL increment the digit count on each accept; an accept that brings the count to NUM_DIGITS SHALL move the state to HOLD on the same edge, giving 1-cycle latency from the last accept to out_valid.
REQ-016 SHALL, in FILL with flush = 1 and resulting count >= 1, move to HOLD with the partial word zero-padded in its upper nibbles, so the numeric value is preserved.
REQ-017 SHALL, when flush and a digit accept occur in the same cycle, include that digit in the emitted word.
REQ-018 SHALL ignore flush when the count is 0 and no digit is accepted that cycle.
REQ-019 SHALL ignore flush while in HOLD.
REQ-020 SHALL hold packed_out and out_count stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL, in HOLD with out_ready = 1, return to FILL with the accumulator and count cleared.
REQ-022 SHALL NOT accept a new digit on the cycle the word is consumed, because in_ready is still 0 on that cycle.
REQ-023 SHALL drive out_count = NUM_DIGITS for a full word and the partial count for a flushed word.

Reset
REQ-024 SHALL, while rst = 1 at a clock edge, set the state to FILL, clear the accumulator and count, drive packed_out = 0, out_count = 0, out_valid = 0 and in_ready = 1, and clear digit_err.
REQ-025 SHALL discard any partial or held word when rst is asserted mid-operation, with no output emitted.

Configuration
REQ-026 SHALL, with BCD_DIGIT_CHECK_EN defined, discard any accepted digit with bcd_in > 9 (no shift, no count change) and set digit_err, which stays set until rst.
REQ-027 SHALL, with BCD_DIGIT_CHECK_EN defined, still honour a flush that arrives together with a discarded digit, using the existing count.
REQ-028 SHALL, without BCD_DIGIT_CHECK_EN, pack every accepted nibble unchecked and omit the digit_err port.

Verification
REQ-029 SHALL cover this scenario: NUM_DIGITS=4, digits 1,2,3,4 on consecutive cycles with out_ready=1 -> out_valid one cycle after the 4th digit, packed_out=16'h1234, out_count=4.
REQ-030 SHALL cover this scenario: digits 7,5 then flush -> packed_out=16'h0075, out_count=2; flush with count 0 -> no output.
REQ-031 SHALL cover this scenario: full word with out_ready held 0 for 5 cycles -> packed_out stable, in_ready=0 throughout, a digit offered during HOLD is not accepted.
REQ-032 SHALL cover this scenario: digit 9 accepted together with flush after digits 3,8 -> packed_out=16'h0389, out_count=3.
REQ-033 SHALL cover this scenario: with BCD_DIGIT_CHECK_EN defined, digits 1,4'hC,2,3,4 -> packed_out=16'h1234 and digit_err=1 until rst.
REQ-034 SHALL cover this scenario: rst asserted after 2 digits -> out_valid=0 and in_ready=1 next cycle; then digits 5,6,7,8 -> packed_out=16'h5678.

Source files
------------

// File: rtl/bcd_digit_packer.sv
// bcd_digit_packer: packs a stream of BCD digits into NUM_DIGITS-wide words.
// The first digit accepted becomes the most significant nibble of the word.
// A flush emits a partial word, zero-padded in its upper nibbles.
//
// Parameters
//   NUM_DIGITS  digits per packed word (2..8)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   bcd_in      one BCD digit from the upstream stage
//   in_valid    bcd_in is valid this cycle
//   in_ready    packer accepts a digit this cycle (FILL state)
//   flush       emit the partial word held so far
//   packed_out  packed BCD word
//   out_count   number of valid digits in packed_out
//   out_valid   packed_out / out_count are valid (HOLD state)
//   out_ready   downstream consumes the word
//   digit_err   sticky invalid-digit flag (BCD_DIGIT_CHECK_EN only)
//
// Build option
//   BCD_DIGIT_CHECK_EN  when defined, digits above 9 are dropped and
//                       digit_err is raised until rst.
module bcd_digit_packer #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [4*NUM_DIGITS-1:0] packed_out,
  output logic [3:0]              out_count,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                    digit_err
`endif
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [3:0] FULL = 4'(NUM_DIGITS);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t state;

  logic         bad;
  logic         take;
  logic [3:0]   cnt_nxt;
  logic [W-1:0] acc_nxt;
  logic         go_hold;

  // packed_out doubles as the accumulator, so a held word is stable
  // simply because nothing shifts while in HOLD.
  always_comb begin
    bad = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    bad = (bcd_in > 4'd9);
`endif
    take    = in_valid && in_ready && !bad;
    cnt_nxt = out_count + {3'b000, take};
    acc_nxt = packed_out;
    if (take) begin
      acc_nxt = {packed_out[W-5:0], bcd_in};
    end
    // A flush with a rejected digit still uses the existing count.
    go_hold = (cnt_nxt == FULL) || (flush && (cnt_nxt != 4'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      packed_out <= '0;
      out_count  <= 4'd0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      unique case (state)
        FILL: begin
          packed_out <= acc_nxt;
          out_count  <= cnt_nxt;
          if (go_hold) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= FILL;
            packed_out <= '0;
            out_count  <= 4'd0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_err <= 1'b0;
    end else if (in_valid && in_ready && bad) begin
      digit_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_digit_packer.sv
// tb_bcd_digit_packer: directed bench for bcd_digit_packer.
// A digit-queue model is checked against the DUT every cycle.
module tb_bcd_digit_packer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   bcd_in;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] packed_out;
  logic [3:0]   out_count;
  logic         out_valid;
  logic         out_ready;
`ifdef BCD_DIGIT_CHECK_EN
  logic         digit_err;
`endif

  bcd_digit_packer #(.NUM_DIGITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .packed_out (packed_out),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .digit_err  (digit_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit live  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the word is the list of accepted digits, read as a base-16
  // number; HOLD is just "a word is waiting".
  int q[$];
  bit m_hold = 0;
  bit m_err  = 0;
  bit check_en;

  initial begin
    check_en = 0;
`ifdef BCD_DIGIT_CHECK_EN
    check_en = 1;
`endif
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_hold = 0;
      m_err  = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        q.delete();
      end
    end else begin
      if (in_valid) begin
        if (check_en && bcd_in > 9) m_err = 1;
        else q.push_back(int'(bcd_in));
      end
      if (q.size() == N || (flush && q.size() > 0)) m_hold = 1;
    end
  end

  function automatic logic [W-1:0] m_word();
    logic [W-1:0] w = '0;
    foreach (q[i]) w = w * 16 + W'(q[i]);
    return w;
  endfunction

  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      if (m_hold) begin
        chk("packed_out", 32'(packed_out), 32'(m_word()));
        chk("out_count", 32'(out_count), 32'(q.size()));
      end
`ifdef BCD_DIGIT_CHECK_EN
      chk("digit_err", 32'(digit_err), 32'(m_err));
`endif
    end
  end

  // Apply inputs at a negedge, return at the next negedge.
  task automatic step(bit v, logic [3:0] d, bit f, bit r, bit rs = 0);
    in_valid  = v;
    bcd_in    = d;
    flush     = f;
    out_ready = r;
    rst       = rs;
    @(negedge clk);
  endtask

  task automatic lit(string nm, logic [W-1:0] w, logic [3:0] c);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_word"}, 32'(packed_out), 32'(w));
    chk({nm, "_count"}, 32'(out_count), 32'(c));
  endtask

  initial begin
    rst = 1; in_valid = 0; bcd_in = 0; flush = 0; out_ready = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    live = 1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_word", 32'(packed_out), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);

    // full word, consumed immediately
    step(1, 1, 0, 1); step(1, 2, 0, 1);
    step(1, 3, 0, 1); step(1, 4, 0, 1);
    lit("full", 16'h1234, 4'd4);
    step(0, 0, 0, 1);

    // partial flush, then flush on empty
    step(1, 7, 0, 0); step(1, 5, 0, 0);
    step(0, 0, 1, 0);
    lit("flush", 16'h0075, 4'd2);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("empty_flush", 32'(out_valid), 32'd0);

    // backpressure; digits and flush offered in HOLD are ignored
    step(1, 9, 0, 0); step(1, 8, 0, 0);
    step(1, 7, 0, 0); step(1, 6, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 5, 1, 0);
      lit("hold", 16'h9876, 4'd4);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    step(1, 5, 0, 1);
    step(0, 0, 1, 0);
    chk("no_accept_on_consume", 32'(out_valid), 32'd0);

    // digit together with flush
    step(1, 3, 0, 0); step(1, 8, 0, 0);
    step(1, 9, 1, 0);
    lit("dig_flush", 16'h0389, 4'd3);
    step(0, 0, 0, 1);

`ifdef BCD_DIGIT_CHECK_EN
    step(1, 1, 0, 0); step(1, 4'hC, 0, 0);
    chk("err_set", 32'(digit_err), 32'd1);
    step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
    lit("check", 16'h1234, 4'd4);
    step(0, 0, 0, 1);
    step(1, 4'hF, 1, 0);
    chk("bad_flush_empty", 32'(out_valid), 32'd0);
    step(1, 6, 0, 0);
    step(1, 4'hA, 1, 0);
    lit("bad_flush", 16'h0006, 4'd1);
    step(0, 0, 0, 1);
    chk("err_sticky", 32'(digit_err), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("err_clear", 32'(digit_err), 32'd0);
`else
    step(1, 1, 0, 0); step(1, 4'hC, 0, 0);
    step(1, 2, 0, 0); step(1, 3, 0, 0);
    lit("nocheck", 16'h1C23, 4'd4);
    step(0, 0, 0, 1);
`endif

    // reset mid-word discards it
    step(1, 1, 0, 0); step(1, 2, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    step(1, 5, 0, 0); step(1, 6, 0, 0);
    step(1, 7, 0, 0); step(1, 8, 0, 0);
    lit("after_rst", 16'h5678, 4'd4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
